timebase_generator: RTL and testbench

- Parametrised timebase for the alarm clock. It divides the system clock into single-cycle second, minute and hour strobes.
- Exposes the running second and minute counts.
- Adds count enable, a fast-forward test mode and a synchronous phase-realign clear.
- Sits between the clock source and the time-keeping/alarm-compare logic. All downstream counters advance on its strobes.

---
 rtl/timebase_pkg.sv | 15 +
 rtl/mod_counter.sv | 51 +++++
 rtl/timebase_generator.sv | 95 +++++++++
 tb/tb_timebase_generator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared constants and width helper for the alarm-clock timebase.
package timebase_pkg;

  localparam int CLKS_PER_SEC_DEF = 256;
  localparam int SEC_PER_MIN_DEF  = 60;
  localparam int MIN_PER_HOUR_DEF = 60;

  // Counter width for a modulus n: clog2(n), but never narrower than one bit.
  function automatic int width_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous clear, increment enable and a registered
// wrap flag that is high for the cycle after an increment at N-1.
module mod_counter
  import timebase_pkg::*;
#(
  parameter int N = 2,
  parameter int W = width_of(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         at_max;

  assign at_max = (count_q == MAX);

  // Next count: clear wins, then increment with explicit wrap at N-1.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      wrap_d  = at_max;
      count_d = at_max ? '0 : count_q + W'(1);
    end
  end

  // Count and wrap flag registers, asynchronously reset to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/timebase_generator.sv
// Timebase for the alarm clock: divides the system clock into single-cycle
// second/minute/hour strobes and exposes the running second and minute counts.
// Edge priority is sync_clear, then enable=0, then counting. In fast mode every
// enabled edge is a second tick and the prescaler is held at zero.
module timebase_generator
  import timebase_pkg::*;
#(
  parameter int CLKS_PER_SEC = CLKS_PER_SEC_DEF,
  parameter int SEC_PER_MIN  = SEC_PER_MIN_DEF,
  parameter int MIN_PER_HOUR = MIN_PER_HOUR_DEF
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                fast,
  input  logic                                sync_clear,
  output logic                                one_second,
  output logic                                one_minute,
  output logic                                one_hour,
  output logic [width_of(SEC_PER_MIN)-1:0]    sec_count,
  output logic [width_of(MIN_PER_HOUR)-1:0]   min_count
);

  localparam int PRE_W = width_of(CLKS_PER_SEC);
  localparam int SEC_W = width_of(SEC_PER_MIN);
  localparam int MIN_W = width_of(MIN_PER_HOUR);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_PER_MIN - 1);

  logic [PRE_W-1:0] pre_count;
  logic [SEC_W-1:0] sec_count_w;
  logic [MIN_W-1:0] min_count_w;

  logic pre_inc, pre_clear, pre_wrap;
  logic fast_tick, sec_tick, min_tick;
  logic fast_tick_q, sec_wrap, min_wrap;

  // Tick chain: the prescaler runs only in normal mode; fast mode makes every
  // enabled edge a second tick and pins the prescaler at zero so it restarts
  // cleanly when fast drops.
  always_comb begin
    pre_inc   = enable & ~fast & ~sync_clear;
    pre_clear = sync_clear | (enable & fast);
    fast_tick = enable & fast & ~sync_clear;
    sec_tick  = (pre_inc & (pre_count == PRE_MAX)) | fast_tick;
    min_tick  = sec_tick & (sec_count_w == SEC_MAX);
  end

  mod_counter #(.N(CLKS_PER_SEC), .W(PRE_W)) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .clear_i (pre_clear),
    .inc_i   (pre_inc),
    .count_o (pre_count),
    .wrap_o  (pre_wrap)
  );

  mod_counter #(.N(SEC_PER_MIN), .W(SEC_W)) u_seconds (
    .clock   (clock),
    .reset   (reset),
    .clear_i (sync_clear),
    .inc_i   (sec_tick),
    .count_o (sec_count_w),
    .wrap_o  (sec_wrap)
  );

  mod_counter #(.N(MIN_PER_HOUR), .W(MIN_W)) u_minutes (
    .clock   (clock),
    .reset   (reset),
    .clear_i (sync_clear),
    .inc_i   (min_tick),
    .count_o (min_count_w),
    .wrap_o  (min_wrap)
  );

  // Registered record of a fast-mode tick; the normal-mode tick is the
  // prescaler's own registered wrap flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fast_tick_q <= 1'b0;
    end else begin
      fast_tick_q <= fast_tick;
    end
  end

  // Fast and normal ticks are mutually exclusive on any edge, so at most one
  // of the two flops is high in a given cycle.
  assign one_second = pre_wrap | fast_tick_q;
  assign one_minute = sec_wrap;
  assign one_hour   = min_wrap;
  assign sec_count  = sec_count_w;
  assign min_count  = min_count_w;

endmodule

// File: tb/tb_timebase_generator.sv
// Directed bench for timebase_generator: a small-parameter instance (4,3,2)
// driven from a table of vectors, and a default instance exercised with
// hand-written long sequences (second/minute periods, enable gap, fast mode,
// phase clear, asynchronous reset).
module tb_timebase_generator;

  logic clock;
  logic reset;

  // Default-parameter instance signals
  logic       d_enable, d_fast, d_clear;
  logic       d_one_second, d_one_minute, d_one_hour;
  logic [5:0] d_sec, d_min;

  // Small-parameter instance signals (4 clks/sec, 3 sec/min, 2 min/hour)
  logic       s_enable, s_fast, s_clear;
  logic       s_one_second, s_one_minute, s_one_hour;
  logic [1:0] s_sec;
  logic [0:0] s_min;

  int n_checks;
  int n_fail;

  timebase_generator dut_d (
    .clock      (clock),
    .reset      (reset),
    .enable     (d_enable),
    .fast       (d_fast),
    .sync_clear (d_clear),
    .one_second (d_one_second),
    .one_minute (d_one_minute),
    .one_hour   (d_one_hour),
    .sec_count  (d_sec),
    .min_count  (d_min)
  );

  timebase_generator #(.CLKS_PER_SEC(4), .SEC_PER_MIN(3), .MIN_PER_HOUR(2)) dut_s (
    .clock      (clock),
    .reset      (reset),
    .enable     (s_enable),
    .fast       (s_fast),
    .sync_clear (s_clear),
    .one_second (s_one_second),
    .one_minute (s_one_minute),
    .one_hour   (s_one_hour),
    .sec_count  (s_sec),
    .min_count  (s_min)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic       fast;
    logic       clr;
    int         reps;
    int         exp_sec;
    int         exp_min;
    logic [2:0] exp_str;   // {hour, minute, second}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic f, input logic c,
                              input int reps, input int sec, input int mn,
                              input logic [2:0] str);
    vec_t v;
    v.en = en; v.fast = f; v.clr = c; v.reps = reps;
    v.exp_sec = sec; v.exp_min = mn; v.exp_str = str;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change 1ns after an edge, outputs sampled there too.
  task automatic step_d(input logic en, input logic f, input logic c);
    d_enable = en; d_fast = f; d_clear = c;
    @(posedge clock);
    #1;
  endtask

  task automatic step_s(input logic en, input logic f, input logic c);
    s_enable = en; s_fast = f; s_clear = c;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    d_enable = 1'b0; d_fast = 1'b0; d_clear = 1'b0;
    s_enable = 1'b0; s_fast = 1'b0; s_clear = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_d_zero(input string name);
    check({name, "_sec"}, 32'(d_sec), 0);
    check({name, "_min"}, 32'(d_min), 0);
    check({name, "_str"}, 32'({d_one_hour, d_one_minute, d_one_second}), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Small-instance vector table, counted from reset release.
    tbl.push_back(mk(1,0,0,3, 0,0,3'b000));  // edges 1-3
    tbl.push_back(mk(1,0,0,1, 1,0,3'b001));  // edge 4: first second
    tbl.push_back(mk(1,0,0,3, 1,0,3'b000));
    tbl.push_back(mk(1,0,0,1, 2,0,3'b001));  // edge 8
    tbl.push_back(mk(1,0,0,3, 2,0,3'b000));
    tbl.push_back(mk(1,0,0,1, 0,1,3'b011));  // edge 12: minute
    tbl.push_back(mk(1,0,0,3, 0,1,3'b000));
    tbl.push_back(mk(1,0,0,1, 1,1,3'b001));  // edge 16
    tbl.push_back(mk(1,0,0,3, 1,1,3'b000));
    tbl.push_back(mk(1,0,0,1, 2,1,3'b001));  // edge 20
    tbl.push_back(mk(1,0,0,3, 2,1,3'b000));
    tbl.push_back(mk(1,0,0,1, 0,0,3'b111));  // edge 24: hour, all strobes
    tbl.push_back(mk(1,0,0,2, 0,0,3'b000));  // prescaler to 2
    tbl.push_back(mk(0,0,0,3, 0,0,3'b000));  // disabled gap holds
    tbl.push_back(mk(1,0,0,1, 0,0,3'b000));  // prescaler 3
    tbl.push_back(mk(1,0,0,1, 1,0,3'b001));  // tick after gap
    tbl.push_back(mk(1,0,0,3, 1,0,3'b000));  // prescaler 3
    tbl.push_back(mk(0,0,0,1, 1,0,3'b000));  // disabled on would-be tick edge
    tbl.push_back(mk(1,0,0,1, 2,0,3'b001));  // deferred tick
    tbl.push_back(mk(1,1,0,1, 0,1,3'b011));  // fast: every edge ticks
    tbl.push_back(mk(1,1,0,1, 1,1,3'b001));
    tbl.push_back(mk(1,1,0,1, 2,1,3'b001));
    tbl.push_back(mk(1,1,0,1, 0,0,3'b111));
    tbl.push_back(mk(1,1,0,1, 1,0,3'b001));
    tbl.push_back(mk(1,0,0,3, 1,0,3'b000));  // prescaler was held at 0
    tbl.push_back(mk(1,0,0,1, 2,0,3'b001));
    tbl.push_back(mk(1,0,0,2, 2,0,3'b000));  // prescaler 2
    tbl.push_back(mk(1,1,0,1, 0,1,3'b011));  // fast mid-count resets prescaler
    tbl.push_back(mk(1,0,0,3, 0,1,3'b000));
    tbl.push_back(mk(1,0,0,1, 1,1,3'b001));  // 4 cycles later, not 2
    tbl.push_back(mk(0,1,0,1, 1,1,3'b000));  // fast while disabled: hold
    tbl.push_back(mk(1,0,0,2, 1,1,3'b000));  // prescaler 2
    tbl.push_back(mk(1,0,1,1, 0,0,3'b000));  // sync_clear
    tbl.push_back(mk(1,0,0,3, 0,0,3'b000));
    tbl.push_back(mk(1,0,0,1, 1,0,3'b001));  // full period after clear
    tbl.push_back(mk(1,0,0,3, 1,0,3'b000));  // prescaler 3
    tbl.push_back(mk(1,0,1,1, 0,0,3'b000));  // clear beats a due tick
    tbl.push_back(mk(0,0,1,1, 0,0,3'b000));  // clear while disabled
    tbl.push_back(mk(1,1,1,1, 0,0,3'b000));  // clear beats fast tick
    tbl.push_back(mk(1,0,0,3, 0,0,3'b000));
    tbl.push_back(mk(1,0,0,1, 1,0,3'b001));

    // Reset state of both instances
    do_reset();
    check_d_zero("d_reset");
    check("s_reset_sec", 32'(s_sec), 0);
    check("s_reset_min", 32'(s_min), 0);
    check("s_reset_str", 32'({s_one_hour, s_one_minute, s_one_second}), 0);

    // Table-driven pass on the small instance
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        step_s(tbl[i].en, tbl[i].fast, tbl[i].clr);
        check($sformatf("s_vec%0d_sec", i), 32'(s_sec), 32'(tbl[i].exp_sec));
        check($sformatf("s_vec%0d_min", i), 32'(s_min), 32'(tbl[i].exp_min));
        check($sformatf("s_vec%0d_str", i),
              32'({s_one_hour, s_one_minute, s_one_second}), 32'(tbl[i].exp_str));
      end
    end
    s_enable = 1'b0; s_fast = 1'b0; s_clear = 1'b0;

    // Defaults: one_second every 256 cycles, first minute at cycle 15360
    do_reset();
    for (int k = 1; k <= 15360; k++) begin
      step_d(1, 0, 0);
      check("d_run_second", 32'(d_one_second), 32'((k % 256) == 0));
      if ((k % 256) == 0) begin
        check("d_run_minute", 32'(d_one_minute), 32'(k == 15360));
        check("d_run_sec", 32'(d_sec), 32'((k / 256) % 60));
      end
    end
    check("d_run_min", 32'(d_min), 1);
    check("d_run_hour", 32'(d_one_hour), 0);

    // Enable dropped at prescaler=100 for 50 cycles
    do_reset();
    repeat (100) step_d(1, 0, 0);
    for (int k = 0; k < 50; k++) begin
      step_d(0, 0, 0);
      check("d_gap_quiet", 32'({d_one_hour, d_one_minute, d_one_second}), 0);
    end
    for (int k = 1; k <= 156; k++) begin
      step_d(1, 0, 0);
      check("d_gap_resume", 32'(d_one_second), 32'(k == 156));
    end
    check("d_gap_sec", 32'(d_sec), 1);

    // Fast mode: a tick every cycle, minute on the 60th
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      step_d(1, 1, 0);
      check("d_fast_second", 32'(d_one_second), 1);
      check("d_fast_sec", 32'(d_sec), 32'(k % 60));
      check("d_fast_minute", 32'(d_one_minute), 32'(k == 60));
    end
    check("d_fast_min", 32'(d_min), 1);
    for (int k = 1; k <= 256; k++) begin
      step_d(1, 0, 0);
      check("d_after_fast", 32'(d_one_second), 32'(k == 256));
    end

    // sync_clear with sec_count=30, prescaler=200
    do_reset();
    repeat (30 * 256 + 200) step_d(1, 0, 0);
    check("d_pre_clear_sec", 32'(d_sec), 30);
    step_d(1, 0, 1);
    check_d_zero("d_clear");
    for (int k = 1; k <= 256; k++) begin
      step_d(1, 0, 0);
      check("d_clear_realign", 32'(d_one_second), 32'(k == 256));
    end
    check("d_clear_sec", 32'(d_sec), 1);

    // Asynchronous reset between edges
    do_reset();
    repeat (5) step_d(1, 1, 0);
    check("d_async_pre_sec", 32'(d_sec), 5);
    check("d_async_pre_str", 32'(d_one_second), 1);
    #3;
    reset = 1'b1;
    #1;
    check_d_zero("d_async");
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      step_d(1, 0, 0);
      check("d_async_restart", 32'(d_one_second), 32'(k == 256));
    end
    check("d_async_restart_sec", 32'(d_sec), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
